// File: rtl/wifire_rx_bank_ctrl_pkg.sv
// Shared types and constants for the wifire receive-side MSDU bank controller.
// Bank states, writer FSM encodings and settings-bus offsets live here.
package wifire_rx_bank_ctrl_pkg;

  localparam int unsigned NBANK  = 2;
  localparam int unsigned LEN_W  = 7;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;

  localparam logic [1:0] BANK_FREE  = 2'd0;
  localparam logic [1:0] BANK_FILL  = 2'd1;
  localparam logic [1:0] BANK_READY = 2'd2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RECV = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  localparam logic [ADDR_W-1:0] OFF_RELEASE    = 8'd0;
  localparam logic [ADDR_W-1:0] OFF_CLEAR_DROP = 8'd1;

  typedef struct packed {
    logic [1:0]       state;
    logic [LEN_W-1:0] len;
  } bank_info_t;

endpackage

// File: rtl/wifire_rx_bank_ctrl_if.sv
// Settings bus, decoder write path and host-side status of the MSDU bank controller.
// The controller connects through the slave modport; its driver uses master.
interface wifire_rx_bank_ctrl_if;
  import wifire_rx_bank_ctrl_pkg::*;

  logic              set_stb;
  logic [ADDR_W-1:0] set_addr;
  logic [DATA_W-1:0] set_data;
  logic              rcv_sfd_i;
  logic              rcv_running_i;
  logic              frame_done_i;
  logic [LEN_W-1:0]  len_i;
  logic              msdu_stb_i;
  logic [ADDR_W-1:0] msdu_pos_i;
  logic              wr_en_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic              rd_bank_o;
  logic [LEN_W-1:0]  frame_len_o;
  logic [2*NBANK-1:0] bank_state_o;
  logic              irq_frame_o;
  logic [CNT_W-1:0]  drop_cnt_o;

  modport master (
    output set_stb, set_addr, set_data, rcv_sfd_i, rcv_running_i,
           frame_done_i, len_i, msdu_stb_i, msdu_pos_i,
    input  wr_en_o, wr_addr_o, rd_bank_o, frame_len_o, bank_state_o,
           irq_frame_o, drop_cnt_o
  );

  modport slave (
    input  set_stb, set_addr, set_data, rcv_sfd_i, rcv_running_i,
           frame_done_i, len_i, msdu_stb_i, msdu_pos_i,
    output wr_en_o, wr_addr_o, rd_bank_o, frame_len_o, bank_state_o,
           irq_frame_o, drop_cnt_o
  );

endinterface

// File: rtl/wifire_rx_bank_ctrl_bank_slot.sv
// One MSDU buffer bank: FREE/FILL/READY state plus the frame length latched at done.
// Allocation outranks abort/release so a bank freed this cycle can be refilled at once.
module wifire_rx_bank_ctrl_bank_slot
  import wifire_rx_bank_ctrl_pkg::*;
(
  input  logic             dsp_clk,
  input  logic             reset,
  input  logic             alloc,
  input  logic             done,
  input  logic             abort,
  input  logic             rel,
  input  logic [LEN_W-1:0] len_i,
  output bank_info_t       info
);

  always_ff @(posedge dsp_clk or posedge reset) begin
    if (reset) begin
      info <= '0;
    end else if (alloc) begin
      info.state <= BANK_FILL;
    end else if (done) begin
      info.state <= BANK_READY;
      info.len   <= len_i;
    end else if (abort || rel) begin
      info.state <= BANK_FREE;
    end
  end

endmodule

// File: rtl/wifire_rx_bank_ctrl.sv
// Ping-pong MSDU buffer controller: assigns a free bank per frame at SFD, gates decoder
// writes into it, hands completed banks to the host oldest-first and counts dropped frames.
module wifire_rx_bank_ctrl
  import wifire_rx_bank_ctrl_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE = 8'd0
) (
  input logic dsp_clk,
  input logic reset,
  wifire_rx_bank_ctrl_if.slave bus
);

  bank_info_t       info [NBANK];
  logic [NBANK-1:0] is_ready;
  logic [NBANK-1:0] avail;
  logic [NBANK-1:0] alloc_vec;
  logic [NBANK-1:0] done_vec;
  logic [NBANK-1:0] abort_vec;
  logic [NBANK-1:0] rel_vec;
  logic [1:0]       fsm_q, fsm_d;
  logic             wr_bank_q, wr_bank_d;
  logic             oldest_q, oldest_d;
  logic             other_bank;
  logic             run_q;
  logic             run_fall;
  logic             rd_bank_c;
  logic             rel_cmd;
  logic             clr_cmd;
  logic             drop;
  logic             rd_bank_q;
  logic             irq_q;
  logic [LEN_W-1:0] frame_len_q;
  logic [CNT_W-1:0] drop_cnt_q;
  logic             unused_ok;

  for (genvar g = 0; g < NBANK; g++) begin : g_slot
    assign is_ready[g] = (info[g].state == BANK_READY);
    wifire_rx_bank_ctrl_bank_slot u_slot (
      .dsp_clk (dsp_clk),
      .reset   (reset),
      .alloc   (alloc_vec[g]),
      .done    (done_vec[g]),
      .abort   (abort_vec[g]),
      .rel     (rel_vec[g]),
      .len_i   (bus.len_i),
      .info    (info[g])
    );
  end

  // Oldest READY bank; a lone READY bank wins regardless of the pointer.
  always_comb begin
    rd_bank_c = 1'b0;
    if (&is_ready)        rd_bank_c = oldest_q;
    else if (is_ready[1]) rd_bank_c = 1'b1;
  end

  assign rel_cmd    = bus.set_stb && (bus.set_addr == 8'(BASE + OFF_RELEASE)) && (|is_ready);
  assign clr_cmd    = bus.set_stb && (bus.set_addr == 8'(BASE + OFF_CLEAR_DROP));
  assign rel_vec[0] = rel_cmd && !rd_bank_c;
  assign rel_vec[1] = rel_cmd && rd_bank_c;
  assign run_fall   = run_q && !bus.rcv_running_i;
  assign other_bank = ~wr_bank_q;

  // Writer FSM next state and per-bank commands.
  always_comb begin
    fsm_d     = fsm_q;
    wr_bank_d = wr_bank_q;
    oldest_d  = oldest_q;
    alloc_vec = '0;
    done_vec  = '0;
    abort_vec = '0;
    avail     = '0;
    drop      = 1'b0;
    for (int i = 0; i < NBANK; i++) begin
      avail[i] = (info[i].state != BANK_READY) || rel_vec[i];
    end
    if (rel_cmd) oldest_d = ~rd_bank_c;
    if (bus.rcv_sfd_i) begin
      for (int i = 0; i < NBANK; i++) begin
        abort_vec[i] = (info[i].state == BANK_FILL);
      end
      if (avail[0]) begin
        alloc_vec[0] = 1'b1;
        wr_bank_d    = 1'b0;
        fsm_d        = ST_RECV;
      end else if (avail[1]) begin
        alloc_vec[1] = 1'b1;
        wr_bank_d    = 1'b1;
        fsm_d        = ST_RECV;
      end else begin
        drop  = 1'b1;
        fsm_d = ST_DROP;
      end
    end else begin
      case (fsm_q)
        ST_RECV: begin
          if (bus.frame_done_i) begin
            done_vec[wr_bank_q] = 1'b1;
            fsm_d               = ST_IDLE;
            if (!(is_ready[other_bank] && !rel_vec[other_bank])) oldest_d = wr_bank_q;
          end else if (run_fall) begin
            abort_vec[wr_bank_q] = 1'b1;
            fsm_d                = ST_IDLE;
          end
        end
        ST_DROP: begin
          if (bus.frame_done_i || run_fall) fsm_d = ST_IDLE;
        end
        ST_IDLE: fsm_d = ST_IDLE;
        default: fsm_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge dsp_clk or posedge reset) begin
    if (reset) begin
      fsm_q       <= ST_IDLE;
      wr_bank_q   <= 1'b0;
      oldest_q    <= 1'b0;
      run_q       <= 1'b0;
      rd_bank_q   <= 1'b0;
      irq_q       <= 1'b0;
      frame_len_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      fsm_q       <= fsm_d;
      wr_bank_q   <= wr_bank_d;
      oldest_q    <= oldest_d;
      run_q       <= bus.rcv_running_i;
      rd_bank_q   <= rd_bank_c;
      irq_q       <= |is_ready;
      frame_len_q <= info[rd_bank_c].len;
      if (clr_cmd) begin
        drop_cnt_q <= drop ? CNT_W'(1) : '0;
      end else if (drop && (drop_cnt_q != '1)) begin
        drop_cnt_q <= drop_cnt_q + CNT_W'(1);
      end
    end
  end

  // Write path is combinational so decoder bytes land in RAM with no added latency.
  assign bus.wr_en_o      = (fsm_q == ST_RECV) && bus.msdu_stb_i;
  assign bus.wr_addr_o    = (fsm_q == ST_RECV) ? {wr_bank_q, bus.msdu_pos_i[LEN_W-1:0]} : '0;
  assign bus.rd_bank_o    = rd_bank_q;
  assign bus.frame_len_o  = frame_len_q;
  assign bus.bank_state_o = {info[1].state, info[0].state};
  assign bus.irq_frame_o  = irq_q;
  assign bus.drop_cnt_o   = drop_cnt_q;

  assign unused_ok = ^{bus.set_data, bus.msdu_pos_i[ADDR_W-1]};

endmodule

// File: tb/tb_wifire_rx_bank_ctrl.sv
// Directed bench for wifire_rx_bank_ctrl: frame capture, host release ordering,
// drop counting with saturation, aborts, same-cycle release/SFD and async reset.
module tb_wifire_rx_bank_ctrl;
  import wifire_rx_bank_ctrl_pkg::*;

  logic dsp_clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  wifire_rx_bank_ctrl_if bus ();

  wifire_rx_bank_ctrl #(.BASE(8'd0)) dut (
    .dsp_clk (dsp_clk),
    .reset   (reset),
    .bus     (bus)
  );

  initial dsp_clk = 1'b0;
  always #5 dsp_clk = ~dsp_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge dsp_clk);
  endtask

  task automatic set_cmd(input logic [7:0] addr);
    bus.set_stb  = 1'b1;
    bus.set_addr = addr;
    bus.set_data = 32'hDEAD_BEEF;
    tick();
    bus.set_stb  = 1'b0;
    tick();
  endtask

  task automatic send_frame(input int n, input int len, input logic exp_wr, input logic exp_bank);
    bus.rcv_sfd_i     = 1'b1;
    bus.rcv_running_i = 1'b1;
    tick();
    bus.rcv_sfd_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.msdu_stb_i = 1'b1;
      bus.msdu_pos_i = 8'(i);
      #1;
      check("wr_en", 32'(bus.wr_en_o), 32'(exp_wr));
      if (exp_wr) check("wr_addr", 32'(bus.wr_addr_o), 32'({exp_bank, 7'(i)}));
      tick();
    end
    bus.msdu_stb_i   = 1'b0;
    bus.frame_done_i = 1'b1;
    bus.len_i        = 7'(len);
    tick();
    bus.frame_done_i  = 1'b0;
    bus.rcv_running_i = 1'b0;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1;
    bus.set_stb = 1'b0; bus.set_addr = '0; bus.set_data = '0;
    bus.rcv_sfd_i = 1'b0; bus.rcv_running_i = 1'b0; bus.frame_done_i = 1'b0;
    bus.len_i = '0; bus.msdu_stb_i = 1'b0; bus.msdu_pos_i = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_bank_state", 32'(bus.bank_state_o), 32'h0);
    check("rst_irq", 32'(bus.irq_frame_o), 32'h0);
    check("rst_drop", 32'(bus.drop_cnt_o), 32'h0);
    check("rst_wr_en", 32'(bus.wr_en_o), 32'h0);

    // 1: single frame into bank0
    send_frame(10, 10, 1'b1, 1'b0);
    check("t1_bank_state", 32'(bus.bank_state_o), 32'h2);
    check("t1_irq", 32'(bus.irq_frame_o), 32'h1);
    check("t1_rd_bank", 32'(bus.rd_bank_o), 32'h0);
    check("t1_frame_len", 32'(bus.frame_len_o), 32'd10);
    set_cmd(8'd0);
    check("t1_released", 32'(bus.bank_state_o), 32'h0);

    // 2: two frames queued, released oldest first
    send_frame(5, 5, 1'b1, 1'b0);
    send_frame(7, 7, 1'b1, 1'b1);
    check("t2_both_ready", 32'(bus.bank_state_o), 32'hA);
    check("t2_rd_bank0", 32'(bus.rd_bank_o), 32'h0);
    check("t2_len5", 32'(bus.frame_len_o), 32'd5);
    set_cmd(8'd0);
    check("t2_rd_bank1", 32'(bus.rd_bank_o), 32'h1);
    check("t2_len7", 32'(bus.frame_len_o), 32'd7);
    set_cmd(8'd0);
    check("t2_irq_off", 32'(bus.irq_frame_o), 32'h0);

    // 3: drops while both banks are READY
    send_frame(5, 5, 1'b1, 1'b0);
    send_frame(7, 7, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) send_frame(4, 4, 1'b0, 1'b0);
    check("t3_drop3", 32'(bus.drop_cnt_o), 32'd3);
    check("t3_banks_kept", 32'(bus.bank_state_o), 32'hA);
    set_cmd(8'd1);
    check("t3_cleared", 32'(bus.drop_cnt_o), 32'd0);
    bus.rcv_sfd_i = 1'b1;
    repeat (65534) tick();
    check("t3_drop_fffe", 32'(bus.drop_cnt_o), 32'hFFFE);
    tick();
    check("t3_drop_ffff", 32'(bus.drop_cnt_o), 32'hFFFF);
    tick();
    check("t3_drop_sat", 32'(bus.drop_cnt_o), 32'hFFFF);
    bus.set_stb  = 1'b1;
    bus.set_addr = 8'd1;
    tick();
    bus.set_stb   = 1'b0;
    bus.rcv_sfd_i = 1'b0;
    check("t3_clear_and_drop", 32'(bus.drop_cnt_o), 32'd1);
    bus.frame_done_i = 1'b1;
    tick();
    bus.frame_done_i = 1'b0;
    tick();
    set_cmd(8'd0);
    set_cmd(8'd0);
    check("t3_all_free", 32'(bus.bank_state_o), 32'h0);

    // 4: receiver drops out mid-frame, bank0 is reused
    bus.rcv_sfd_i     = 1'b1;
    bus.rcv_running_i = 1'b1;
    tick();
    bus.rcv_sfd_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.msdu_stb_i = 1'b1;
      bus.msdu_pos_i = 8'(i);
      #1;
      check("t4_wr_addr", 32'(bus.wr_addr_o), 32'(i));
      tick();
    end
    bus.msdu_stb_i    = 1'b0;
    bus.rcv_running_i = 1'b0;
    tick();
    tick();
    check("t4_aborted", 32'(bus.bank_state_o), 32'h0);
    check("t4_irq", 32'(bus.irq_frame_o), 32'h0);
    check("t4_no_drop", 32'(bus.drop_cnt_o), 32'd1);
    send_frame(3, 3, 1'b1, 1'b0);
    check("t4_reuse_ready", 32'(bus.bank_state_o), 32'h2);

    // 5: RELEASE and SFD in the same cycle
    send_frame(2, 2, 1'b1, 1'b1);
    check("t5_both_ready", 32'(bus.bank_state_o), 32'hA);
    bus.set_stb       = 1'b1;
    bus.set_addr      = 8'd0;
    bus.rcv_sfd_i     = 1'b1;
    bus.rcv_running_i = 1'b1;
    tick();
    bus.set_stb   = 1'b0;
    bus.rcv_sfd_i = 1'b0;
    check("t5_refill", 32'(bus.bank_state_o), 32'h9);
    check("t5_no_drop", 32'(bus.drop_cnt_o), 32'd1);
    tick();
    check("t5_rd_bank", 32'(bus.rd_bank_o), 32'h1);
    check("t5_frame_len", 32'(bus.frame_len_o), 32'd2);

    // 6: async reset in the middle of a frame
    for (int i = 0; i < 4; i++) begin
      bus.msdu_stb_i = 1'b1;
      bus.msdu_pos_i = 8'(i + 5);
      #1;
      check("t6_wr_addr", 32'(bus.wr_addr_o), 32'(i + 5));
      tick();
    end
    bus.msdu_pos_i = 8'd9;
    #1;
    check("t6_wr_en_pre", 32'(bus.wr_en_o), 32'h1);
    #1;
    reset = 1'b1;
    #1;
    check("t6_wr_en_async", 32'(bus.wr_en_o), 32'h0);
    check("t6_banks_free", 32'(bus.bank_state_o), 32'h0);
    check("t6_irq", 32'(bus.irq_frame_o), 32'h0);
    check("t6_drop", 32'(bus.drop_cnt_o), 32'h0);
    bus.msdu_stb_i    = 1'b0;
    bus.rcv_running_i = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
